rca_word_sequencer: RTL and testbench
=====================================

# rca_word_sequencer

Multi-precision adder controller that sequences a single `six_bit_ripple_carry_adder` over `WORDS` 6-bit slices. It adds two `6*WORDS`-bit operands, least-significant slice first, one slice per clock, and chains the carry through a register. It accepts operands and returns results over valid/ready handshakes, so datapath blocks can use wide addition while the design keeps only one 6-bit adder.

## Interface
- `WORDS`, default 4: number of 6-bit slices. The operand width is `W = 6*WORDS`. Legal values are 1 to 16; any other value is an elaboration error.
- `clk` input, 1 bit: the single clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: the operand set is valid.
- `in_ready` output, 1 bit: the block can accept operands.
- `a` input, `W` bits: operand A.
- `b` input, `W` bits: operand B.
- `carry_in` input, 1 bit: carry into slice 0.
- `out_valid` output, 1 bit: the result is valid.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `sum` output, `W` bits: the result, `(a + b + carry_in) mod 2^W`.
- `carry_out` output, 1 bit: carry out of the top slice.
- `busy` output, 1 bit: high while the block is in RUN.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Output decode:
  - `in_ready = (state == IDLE)`
  - `busy = (state == RUN)`
  - `out_valid = (state == DONE)`
- **IDLE:** when `in_valid && in_ready` at a rising edge, the block captures `a`, `b` and `carry_in`. It clears the slice index `idx` to 0, loads the carry register with `carry_in`, and moves to RUN. If `in_valid` is low, it stays in IDLE.
- **RUN:** the adder input for slice `idx` is `a_reg[6*idx +: 6]`, `b_reg[6*idx +: 6]` and `carry_reg`. Each rising edge:
  - `sum_reg[6*idx +: 6]` takes the adder's sum.
  - `carry_reg` takes the adder's carry-out.
  - `idx` increments.
  - When `idx == WORDS-1`, the block also loads `carry_out` from the adder's carry-out and moves to DONE.
- **DONE:** `sum` and `carry_out` hold stable. When `out_valid && out_ready` at a rising edge, the block moves to IDLE.
- **Output values:** `sum` is driven directly from `sum_reg`, so slices visibly update during RUN. `sum` and `carry_out` are defined only while `out_valid` is high. Between operations they keep the last result until the next RUN overwrites them.
- **Input sampling:** `a`, `b` and `carry_in` are sampled only at acceptance. Changes to them afterwards have no effect on the operation in progress.
- `in_valid` asserted in RUN or DONE is ignored; no operand is captured and nothing is queued.
- Arithmetic is unsigned modulo `2^W`, and `carry_out` is bit `W` of the full sum. Signed overflow is not reported.
- With `WORDS = 1`, RUN lasts exactly one cycle.
- `idx` is `$clog2(WORDS+1)` bits wide and never wraps within an operation.

## Timing
- **Reset values:** `rst_n` low forces the following immediately, regardless of `clk`:
  - state = IDLE, so `in_ready = 1`, `busy = 0` and `out_valid = 0`.
  - `sum = 0`, `carry_out = 0`, `idx = 0`, `carry_reg = 0`.
- **Reset mid-operation:** reset asserted in RUN or DONE aborts the operation and the result is discarded. The first acceptance after `rst_n` deasserts behaves normally.
- **Latency:** if acceptance happens at edge E0, RUN spans edges E1 to E_WORDS. `out_valid` rises immediately after edge E_WORDS, i.e. `WORDS` cycles after acceptance.
- **Throughput:** with `out_ready` held high, the block completes one operation every `WORDS + 2` cycles: one IDLE cycle, `WORDS` RUN cycles and one DONE cycle.
- **Back-pressure:** DONE persists for as long as `out_ready` is low. There is no timeout.
- **No combinational paths:** no input-to-output path exists. Every handshake output is a decode of registered state.

## Test plan
All scenarios use `WORDS = 4` (`W = 24`).
- **Reset:** hold `rst_n` low for 3 cycles with random inputs. Required: `in_ready = 1`, `out_valid = 0`, `busy = 0`, `sum = 0`, `carry_out = 0`.
- **Full carry ripple:** `a = 24'hFFFFFF`, `b = 24'h000001`, `carry_in = 0`. Required: `busy` high for exactly 4 cycles, `out_valid` rising 4 cycles after acceptance, `sum = 24'h000000`, `carry_out = 1`.
- **Alternating patterns:** `a = 24'hAAAAAA`, `b = 24'h555555`.
  - With `carry_in = 0`: `sum = 24'hFFFFFF`, `carry_out = 0`.
  - Repeated with `carry_in = 1`: `sum = 24'h000000`, `carry_out = 1`.
- **Back-pressure:** hold `out_ready` low for 3 cycles in DONE and pulse `in_valid` with new operands. Required:
  - `out_valid` stays high, and `sum` and `carry_out` stay unchanged.
  - `in_ready` stays 0 and the pulsed operands are never captured.
  - After `out_ready` rises, the block returns to IDLE on the next cycle.
- **Reset mid-RUN:** assert `rst_n` low after 2 RUN cycles. Required: immediate IDLE with all outputs at their reset values. Then `24'h123456 + 24'h654321` with `carry_in = 0` must give `sum = 24'h777777`, `carry_out = 0`.
- **Back-to-back:** keep `in_valid` and `out_ready` high. First operation `24'h123456 + 24'h654321`; second `24'h800000 + 24'h800000`, accepted in the first IDLE cycle after the first result. Required:
  - First result: `sum = 24'h777777`, `carry_out = 0`.
  - Second result: `sum = 24'h000000`, `carry_out = 1`.
  - The two acceptances are exactly 6 cycles apart.

Source files
------------

// File: rtl/rca_word_sequencer.sv
// Multi-precision adder: steps one 6-bit ripple-carry adder across WORDS slices,
// least-significant first, with valid/ready handshakes on operands and result.

module six_bit_ripple_carry_adder (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       cin,
    output logic [5:0] sum,
    output logic       cout
);
    logic [6:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 6; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[6];
endmodule

module rca_word_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*WORDS-1:0]   a,
    input  logic [6*WORDS-1:0]   b,
    input  logic                 carry_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*WORDS-1:0]   sum,
    output logic                 carry_out,
    output logic                 busy
);
    localparam int W     = 6 * WORDS;
    localparam int IDX_W = $clog2(WORDS + 1);

    if (WORDS < 1 || WORDS > 16) begin : g_bad_words
        $error("rca_word_sequencer: WORDS must be in 1..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, b_q, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               carry_out_q;

    logic [5:0]         slice_a, slice_b, add_sum;
    logic               add_cout;
    logic               last_slice;

    assign last_slice = (idx_q == IDX_W'(WORDS - 1));

    // Constant-index mux keeps the slice select free of out-of-range indexing.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                slice_a = a_q[6*w +: 6];
                slice_b = b_q[6*w +: 6];
            end
        end
    end

    six_bit_ripple_carry_adder u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_slice) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_in;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx_q == IDX_W'(w)) sum_q[6*w +: 6] <= add_sum;
                    end
                    carry_q <= add_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (last_slice) carry_out_q <= add_cout;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed bench for rca_word_sequencer with WORDS = 4: reset, ripple, patterns,
// back-pressure, reset mid-RUN and back-to-back throughput.

module tb_rca_word_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 6 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    rca_word_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge while IDLE; returns at the negedge just after acceptance.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        carry_in = ci;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid, bounded.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            step();
            lat++;
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic [W-1:0] exp_sum, input logic exp_co, input string tag);
        int lat, busy_n;
        accept(av, bv, ci, tag);
        wait_done(lat, busy_n);
        check({tag, "_latency"}, 32'(lat), 32'(WORDS));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WORDS));
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_carry_out"}, 32'(carry_out), 32'(exp_co));
    endtask

    initial begin
        int lat, busy_n, t0, t1;
        logic [W-1:0] held_sum;
        logic         held_co;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            carry_in  = 1'($urandom);
            step();
        end
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        step();

        run_op(24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, "ripple");
        release_result("ripple");

        run_op(24'hAAAAAA, 24'h555555, 1'b0, 24'hFFFFFF, 1'b0, "alt_c0");
        release_result("alt_c0");

        run_op(24'hAAAAAA, 24'h555555, 1'b1, 24'h000000, 1'b1, "alt_c1");

        // Back-pressure: stay in DONE while new operands are offered.
        held_sum = 24'h000000;
        held_co  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 24'h0F0F0F;
            b        = 24'h010101;
            carry_in = 1'b1;
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'(held_sum));
            check("bp_carry_out", 32'(carry_out), 32'(held_co));
        end
        in_valid = 1'b0;
        release_result("bp");
        step();
        check("bp_no_capture_busy", 32'(busy), 32'd0);
        check("bp_no_capture_sum", 32'(sum), 32'(held_sum));

        // Reset two RUN edges into an operation.
        accept(24'h123456, 24'h654321, 1'b0, "midrst");
        step();
        step();
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_carry_out", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_op(24'h123456, 24'h654321, 1'b0, 24'h777777, 1'b0, "post_rst");
        release_result("post_rst");

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 24'h123456;
        b         = 24'h654321;
        carry_in  = 1'b0;
        check("b2b_first_ready", 32'(in_ready), 32'd1);
        t0 = cyc;
        step();
        a = 24'h800000;
        b = 24'h800000;
        wait_done(lat, busy_n);
        check("b2b_first_latency", 32'(lat), 32'(WORDS));
        check("b2b_first_sum", 32'(sum), 32'h777777);
        check("b2b_first_carry_out", 32'(carry_out), 32'd0);
        step();
        check("b2b_second_ready", 32'(in_ready), 32'd1);
        t1 = cyc;
        check("b2b_spacing", 32'(t1 - t0), 32'd6);
        step();
        in_valid = 1'b0;
        wait_done(lat, busy_n);
        check("b2b_second_latency", 32'(lat), 32'(WORDS));
        check("b2b_second_sum", 32'(sum), 32'h000000);
        check("b2b_second_carry_out", 32'(carry_out), 32'd1);
        step();
        check("b2b_final_idle", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
